threshold_winner_unit: RTL and testbench
========================================

Name: threshold_winner_unit

Overview:
- Multi-channel, streaming successor to the single 4-bit threshold comparator used in the ANN output layer.
- Accepts a stream of neuron activations, one channel per beat, in channel order 0..CHANNELS-1 per frame.
- Gates each activation against a per-channel programmable threshold using a selectable mode.
- Emits the gated values with a valid/ready handshake and reports the frame winner (argmax) for classification.

Parameters:
WIDTH, 8, activation/threshold bit width (unsigned)
CHANNELS, 4, neurons per frame (>=2)
CH_W, $clog2(CHANNELS), channel index width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
mode  in  2  gating mode, sampled per accepted beat
thr_we  in  1  threshold write strobe
thr_idx  in  CH_W  threshold channel to write
thr_data  in  WIDTH  threshold value
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept beat
in_data  in  WIDTH  activation value
in_last  in  1  early frame terminator
out_valid  out  1  gated beat valid
out_ready  in  1  downstream accepts beat
out_data  out  WIDTH  gated value
out_ch  out  CH_W  channel of out_data
out_last  out  1  final beat of frame
win_valid  out  1  one-cycle pulse: frame result ready
win_ch  out  CH_W  winning channel
win_value  out  WIDTH  winning gated value

Behaviour:
- Arithmetic: all comparisons and values are unsigned, WIDTH bits.
- Modes (x = in_data, t = thr[ch]):
  - 0 gate: x if x<=t, else 0.
  - 1 relu-threshold: x if x>=t, else 0.
  - 2 saturate: min(x,t).
  - 3: reserved, behaves as mode 0.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register, no combinational path from in_valid to out_valid).
- Latency: accepted beat appears on out_* on the next cycle.
- out_* held stable while out_valid && !out_ready.
- Channel counter ch:
  - Starts at 0 and increments per accepted beat.
  - Beat is frame-final if ch==CHANNELS-1 or in_last=1; ch returns to 0 after a frame-final beat.
  - in_last on the beat where ch==CHANNELS-1 is redundant and treated identically.
- Thresholds:
  - CHANNELS registers, reset to all-ones (mode 0 then passes every value).
  - A write takes effect the cycle after thr_we.
  - A write to the channel being accepted in the same cycle does not apply: the accepted beat uses the old value.
  - thr_idx>=CHANNELS is ignored.
- Winner tracking:
  - Running max over gated values of the current frame.
  - Strictly-greater replaces, so ties keep the lowest channel.
  - The first beat of a frame always loads the running max.
- Winner report:
  - On the cycle after the frame-final beat is accepted, win_valid=1 for exactly one cycle, with win_ch/win_value = frame result.
  - win_ch/win_value hold until the next report.
  - win_valid is independent of out_ready; the report is issued even if out is stalled.
- All-zero frame: win_ch=0, win_value=0.
- States:
  - IDLE (ch==0, no frame open): first accepted beat → ACCUM, or → REPORT if frame-final.
  - ACCUM: frame-final beat → REPORT.
  - REPORT: lasts 1 cycle, asserts win_valid. A new frame's first beat may be accepted in REPORT; next state is ACCUM, or REPORT again if that beat is also frame-final.
- Reset:
  - Zeros out_valid, out_data, out_ch, out_last, win_valid, win_ch, win_value, ch and the running max; state → IDLE; thresholds → all-ones.
  - Mid-frame reset discards the partial frame with no win_valid.
  - in_ready=1 in the first cycle after reset is released.

Test Plan:
- Reset/passthrough:
  - Stimulus: WIDTH=4, CHANNELS=4, mode 0, default thresholds, frame 3,9,15,2.
  - Response: out_data 3,9,15,2 with out_ch 0..3 and out_last on ch3; win_valid 1 cycle after the last accept, win_ch=2, win_value=15.
- Gate vs saturate:
  - Stimulus: thr = {5,5,5,5}, frame 3,6,5,12.
  - Response: mode 0 → 3,0,5,0, win_ch=2. Mode 1 → 0,6,5,12, win_ch=3. Mode 2 → 3,5,5,5, win_ch=1 (tie keeps lowest index).
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles with the first beat valid.
  - Response: in_ready=0 after one beat is captured; out_data is stable; no beats are lost or duplicated when released; the win result is unchanged.
- Early terminate / threshold race:
  - Stimulus: in_last on ch1 of frame 7,4 (mode 0, thr=all-ones).
  - Response: out_last on ch1; win_ch=0, win_value=7; the next beat is ch0.
  - Stimulus: write thr[1]=2 in the same cycle ch1 (value 4) is accepted.
  - Response: out_data=4, and the new threshold applies from the next frame.
- Reset mid-frame:
  - Stimulus: assert rst after 2 of 4 beats.
  - Response: no win_valid; all outputs 0; the next frame restarts at ch0 with thresholds all-ones.
- Back-to-back frames:
  - Stimulus: continuous in_valid with out_ready=1 across 3 frames.
  - Response: full throughput of 1 beat/cycle; one win_valid pulse per frame, each carrying correct results.

Source files
------------

// File: rtl/threshold_winner_unit.sv
// -----------------------------------------------------------------------------
// threshold_winner_unit
//
// Streaming, multi-channel threshold gate with frame argmax ("winner") report
// for the ANN output layer. Activations arrive one channel per beat in channel
// order 0..CHANNELS-1. Each one is gated against a programmable per-channel
// threshold using a selectable mode. The gated value is then forwarded
// downstream through a single output register.
//
// At the end of every frame the channel with the largest gated value, and that
// value, are reported with a one-cycle win_valid pulse.
//
// Gating modes (x = in_data, t = threshold of the current channel):
//   0 : gate            -> x if x <= t, else 0
//   1 : relu-threshold  -> x if x >= t, else 0
//   2 : saturate        -> min(x, t)
//   3 : reserved, treated as mode 0
//
// Handshake (both sides):
//   A beat transfers on a rising edge where valid && ready. A producer holds
//   its data stable while valid && !ready. The output side uses one register
//   stage:
//     - in_ready = !out_valid || out_ready, so no combinational path runs from
//       in_valid to out_valid.
//     - An accepted beat shows up on out_* on the next cycle.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   mode         gating mode, sampled with each accepted beat
//   thr_we       threshold write strobe
//   thr_idx      channel whose threshold is written (>= CHANNELS is ignored)
//   thr_data     new threshold value
//   in_valid     input beat valid
//   in_ready     unit can accept an input beat
//   in_data      activation value
//   in_last      early frame terminator
//   out_valid    gated beat valid
//   out_ready    downstream accepts the gated beat
//   out_data     gated value
//   out_ch       channel of out_data
//   out_last     final beat of the frame
//   win_valid    one-cycle pulse: the frame result is ready
//   win_ch       winning channel (held until the next report)
//   win_value    winning gated value (held until the next report)
//
// The FSM state is kept in the signal 'state' (type state_t). That gives
// checkers and waveforms a single point to observe frame progress.
// -----------------------------------------------------------------------------
module threshold_winner_unit #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             thr_we,
  input  logic [CH_W-1:0]  thr_idx,
  input  logic [WIDTH-1:0] thr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_last,
  output logic             win_valid,
  output logic [CH_W-1:0]  win_ch,
  output logic [WIDTH-1:0] win_value
);

  // Index of the last channel in a full frame.
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);
  // Number of channels, one bit wider so it can be compared against thr_idx.
  localparam logic [CH_W:0]   CH_COUNT = (CH_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // ch == 0 and no frame open
    S_ACCUM  = 2'd1,  // frame open, collecting beats
    S_REPORT = 2'd2   // win_valid cycle after a frame-final beat
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] thr [CHANNELS];  // per-channel thresholds
  logic [CH_W-1:0]  ch;              // channel of the next input beat
  logic [WIDTH-1:0] max_val;         // running max of the open frame
  logic [CH_W-1:0]  max_ch;          // channel holding max_val

  // ---------------------------------------------------------------------------
  // Beat-level combinational terms
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             frame_final;
  logic             first_beat;
  logic             thr_idx_ok;
  logic [WIDTH-1:0] thr_cur;
  logic [WIDTH-1:0] gated;
  logic             take_new;
  logic [WIDTH-1:0] max_nxt;
  logic [CH_W-1:0]  max_ch_nxt;

  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  // in_last on the last channel is redundant: both terms just mark the end.
  assign frame_final = (ch == LAST_CH) || in_last;
  assign first_beat  = (ch == '0);
  assign thr_idx_ok  = ({1'b0, thr_idx} < CH_COUNT);

  // The threshold is read from the register array before any write in this
  // cycle lands. So a same-cycle write to the accepted channel is not seen by
  // that beat; it is seen from the next beat on.
  always_comb begin
    thr_cur = thr[ch];
    gated   = '0;
    case (mode)
      2'd1:    gated = (in_data >= thr_cur) ? in_data : '0;
      2'd2:    gated = (in_data <  thr_cur) ? in_data : thr_cur;
      default: gated = (in_data <= thr_cur) ? in_data : '0;  // modes 0 and 3
    endcase
  end

  // Running max update. The first beat of a frame always loads. After that a
  // strictly-greater value replaces, so on a tie the lowest channel stays.
  always_comb begin
    take_new   = first_beat || (gated > max_val);
    max_nxt    = take_new ? gated : max_val;
    max_ch_nxt = take_new ? ch    : max_ch;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = frame_final ? S_REPORT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept && frame_final) begin
          state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        // A new frame may begin in the report cycle itself.
        if (accept) begin
          state_nxt = frame_final ? S_REPORT : S_ACCUM;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // The report does not depend on out_ready: it is issued even while the
  // output register is stalled.
  always_comb begin
    win_valid = (state == S_REPORT);
  end

  // ---------------------------------------------------------------------------
  // Threshold registers
  // ---------------------------------------------------------------------------
  // Reset value is all-ones, so mode 0 passes every activation unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        thr[i] <= '1;
      end
    end else if (thr_we && thr_idx_ok) begin
      thr[thr_idx] <= thr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: channel counter, running max, output register, win result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ch        <= '0;
      max_val   <= '0;
      max_ch    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      win_ch    <= '0;
      win_value <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= gated;
        out_ch    <= ch;
        out_last  <= frame_final;
        max_val   <= max_nxt;
        max_ch    <= max_ch_nxt;
        if (frame_final) begin
          // Capture the frame result together with the final beat. It is
          // visible alongside win_valid on the next cycle, then held.
          ch        <= '0;
          win_ch    <= max_ch_nxt;
          win_value <= max_nxt;
        end else begin
          ch <= ch + CH_W'(1);
        end
      end else if (out_ready) begin
        // The output beat was consumed and nothing replaced it.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_threshold_winner_unit.sv
// -----------------------------------------------------------------------------
// tb_threshold_winner_unit
//
// Directed bench for threshold_winner_unit with WIDTH=4 and CHANNELS=4.
// The stimulus is driven 1 time unit after each rising edge, and the outputs
// are checked at that same point, well away from the active edge.
//
// A negedge monitor records:
//   - completed output transfers into obs_q
//   - win reports into win_ch_q / win_val_q
// The scenario tasks compare these records with expected values worked out by
// hand.
// -----------------------------------------------------------------------------
module tb_threshold_winner_unit;

  localparam int W    = 4;
  localparam int CHN  = 4;
  localparam int CH_W = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      mode      = 2'd0;
  logic            thr_we    = 1'b0;
  logic [CH_W-1:0] thr_idx   = '0;
  logic [W-1:0]    thr_data  = '0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data   = '0;
  logic            in_last   = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    out_data;
  logic [CH_W-1:0] out_ch;
  logic            out_last;
  logic            win_valid;
  logic [CH_W-1:0] win_ch;
  logic [W-1:0]    win_value;

  threshold_winner_unit #(.WIDTH(W), .CHANNELS(CHN)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .thr_we    (thr_we),
    .thr_idx   (thr_idx),
    .thr_data  (thr_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .win_valid (win_valid),
    .win_ch    (win_ch),
    .win_value (win_value)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and monitor
  // ---------------------------------------------------------------------------
  int n_cmp   = 0;
  int n_fail  = 0;
  int win_cnt = 0;

  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    obs_q[$];
  logic [CH_W-1:0] win_ch_q[$];
  logic [W-1:0]    win_val_q[$];

  // Inputs only change 1 unit after a rising edge, so the values seen at the
  // negedge are the ones the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back(out_data);
    if (win_valid) begin
      win_cnt++;
      win_ch_q.push_back(win_ch);
      win_val_q.push_back(win_value);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [W-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic write_thr(input logic [CH_W-1:0] idx, input logic [W-1:0] val);
    thr_we   = 1'b1;
    thr_idx  = idx;
    thr_data = val;
    @(posedge clk); #1;
    thr_we   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
    n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid: got %0b want 0", win_valid); end
    n_cmp++; if (win_ch !== 2'd0) begin n_fail++; $display("FAIL reset_win_ch: got %0d want 0", win_ch); end
    n_cmp++; if (win_value !== 4'd0) begin n_fail++; $display("FAIL reset_win_value: got %0d want 0", win_value); end
  endtask

  task automatic test_passthrough();
    int frame[4] = '{3, 9, 15, 2};
    mode = 2'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(W'(frame[i]), 1'b0);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid[%0d]: got %0b want 1", i, out_valid); end
      n_cmp++; if (out_data !== W'(frame[i])) begin n_fail++; $display("FAIL pass_data[%0d]: got %0d want %0d", i, out_data, frame[i]); end
      n_cmp++; if (out_ch !== CH_W'(i)) begin n_fail++; $display("FAIL pass_ch[%0d]: got %0d want %0d", i, out_ch, i); end
      n_cmp++; if (out_last !== (i == 3)) begin n_fail++; $display("FAIL pass_last[%0d]: got %0b want %0b", i, out_last, (i == 3)); end
    end
    n_cmp++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL pass_win_valid: got %0b want 1", win_valid); end
    n_cmp++; if (win_ch !== 2'd2) begin n_fail++; $display("FAIL pass_win_ch: got %0d want 2", win_ch); end
    n_cmp++; if (win_value !== 4'd15) begin n_fail++; $display("FAIL pass_win_value: got %0d want 15", win_value); end
    @(posedge clk); #1;
    n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL pass_win_pulse: got %0b want 0", win_valid); end
    n_cmp++; if (win_value !== 4'd15) begin n_fail++; $display("FAIL pass_win_hold: got %0d want 15", win_value); end
  endtask

  task automatic test_gate_modes();
    int frame[4]  = '{3, 6, 5, 12};
    int exp_m0[4] = '{3, 0, 5, 0};
    int exp_m1[4] = '{0, 6, 5, 12};
    int exp_m2[4] = '{3, 5, 5, 5};
    int exp_wc[3] = '{2, 3, 1};
    int exp_wv[3] = '{5, 12, 5};
    int e;
    for (int c = 0; c < 4; c++) write_thr(CH_W'(c), 4'd5);
    for (int m = 0; m < 3; m++) begin
      mode = 2'(m);
      for (int i = 0; i < 4; i++) begin
        send(W'(frame[i]), 1'b0);
        e = (m == 0) ? exp_m0[i] : (m == 1) ? exp_m1[i] : exp_m2[i];
        n_cmp++; if (out_data !== W'(e)) begin n_fail++; $display("FAIL mode%0d_data[%0d]: got %0d want %0d", m, i, out_data, e); end
      end
      n_cmp++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL mode%0d_win_valid: got %0b want 1", m, win_valid); end
      n_cmp++; if (win_ch !== CH_W'(exp_wc[m])) begin n_fail++; $display("FAIL mode%0d_win_ch: got %0d want %0d", m, win_ch, exp_wc[m]); end
      n_cmp++; if (win_value !== W'(exp_wv[m])) begin n_fail++; $display("FAIL mode%0d_win_value: got %0d want %0d", m, win_value, exp_wv[m]); end
    end
    mode = 2'd0;
  endtask

  task automatic test_backpressure();
    int wins0;
    for (int c = 0; c < 4; c++) write_thr(CH_W'(c), 4'd15);
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(4'd1); exp_q.push_back(4'd8); exp_q.push_back(4'd4); exp_q.push_back(4'd6);
    wins0 = win_cnt;
    mode = 2'd0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'd1; in_last = 1'b0;
    @(posedge clk); #1;           // first beat captured
    in_data = 4'd8;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, in_ready); end
      n_cmp++; if (out_data !== 4'd1) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %0d want 1", k, out_data); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", k, out_valid); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;           // 8 accepted
    in_data = 4'd4;
    @(posedge clk); #1;           // 4 accepted
    in_data = 4'd6;
    @(posedge clk); #1;           // 6 accepted, frame final
    in_valid = 1'b0;
    n_cmp++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL bp_win_valid: got %0b want 1", win_valid); end
    @(posedge clk); #1;           // last beat drains
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_beat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (win_cnt - wins0 != 1) begin n_fail++; $display("FAIL bp_win_pulses: got %0d want 1", win_cnt - wins0); end
    n_cmp++; if (win_ch !== 2'd1) begin n_fail++; $display("FAIL bp_win_ch: got %0d want 1", win_ch); end
    n_cmp++; if (win_value !== 4'd8) begin n_fail++; $display("FAIL bp_win_value: got %0d want 8", win_value); end
  endtask

  task automatic test_early_last_and_race();
    mode = 2'd0;
    send(4'd7, 1'b0);
    send(4'd4, 1'b1);
    n_cmp++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL early_out_last: got %0b want 1", out_last); end
    n_cmp++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL early_out_ch: got %0d want 1", out_ch); end
    n_cmp++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL early_win_valid: got %0b want 1", win_valid); end
    n_cmp++; if (win_ch !== 2'd0) begin n_fail++; $display("FAIL early_win_ch: got %0d want 0", win_ch); end
    n_cmp++; if (win_value !== 4'd7) begin n_fail++; $display("FAIL early_win_value: got %0d want 7", win_value); end
    send(4'd5, 1'b0);
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL early_next_ch: got %0d want 0", out_ch); end
    // Threshold write to ch1 in the same cycle that ch1 is accepted.
    thr_we = 1'b1; thr_idx = 2'd1; thr_data = 4'd2;
    send(4'd4, 1'b1);
    thr_we = 1'b0;
    n_cmp++; if (out_data !== 4'd4) begin n_fail++; $display("FAIL race_old_thr: got %0d want 4", out_data); end
    send(4'd3, 1'b0);
    send(4'd4, 1'b1);
    n_cmp++; if (out_data !== 4'd0) begin n_fail++; $display("FAIL race_new_thr: got %0d want 0", out_data); end
    n_cmp++; if (win_value !== 4'd3) begin n_fail++; $display("FAIL race_win_value: got %0d want 3", win_value); end
    write_thr(2'd1, 4'd15);
  endtask

  task automatic test_mid_frame_reset();
    int wins0;
    write_thr(2'd0, 4'd1);
    wins0 = win_cnt;
    send(4'd2, 1'b0);
    send(4'd9, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'd0) begin n_fail++; $display("FAIL mrst_out_data: got %0d want 0", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL mrst_out_ch: got %0d want 0", out_ch); end
    n_cmp++; if (win_value !== 4'd0) begin n_fail++; $display("FAIL mrst_win_value: got %0d want 0", win_value); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (win_cnt != wins0) begin n_fail++; $display("FAIL mrst_no_win: got %0d want %0d", win_cnt, wins0); end
    send(4'd12, 1'b0);
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL mrst_restart_ch: got %0d want 0", out_ch); end
    n_cmp++; if (out_data !== 4'd12) begin n_fail++; $display("FAIL mrst_thr_restored: got %0d want 12", out_data); end
    send(4'd3, 1'b0);
    send(4'd7, 1'b0);
    send(4'd1, 1'b0);
    n_cmp++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_win_valid: got %0b want 1", win_valid); end
    n_cmp++; if (win_ch !== 2'd0) begin n_fail++; $display("FAIL mrst_win_ch: got %0d want 0", win_ch); end
    n_cmp++; if (win_value !== 4'd12) begin n_fail++; $display("FAIL mrst_win_value2: got %0d want 12", win_value); end
  endtask

  task automatic test_back_to_back();
    int frames[12] = '{4, 11, 11, 2,  0, 0, 0, 0,  1, 2, 3, 14};
    int exp_wc[3]  = '{1, 0, 3};
    int exp_wv[3]  = '{11, 0, 14};
    int wins0;
    @(posedge clk); #1;
    obs_q.delete(); exp_q.delete(); win_ch_q.delete(); win_val_q.delete();
    wins0 = win_cnt;
    mode = 2'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(W'(frames[i]));
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %0b want 1", i, in_ready); end
      send(W'(frames[i]), 1'b0);
    end
    @(posedge clk); #1;
    n_cmp++; if (obs_q.size() != 12) begin n_fail++; $display("FAIL b2b_beat_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (win_cnt - wins0 != 3) begin n_fail++; $display("FAIL b2b_win_pulses: got %0d want 3", win_cnt - wins0); end
    for (int f = 0; f < 3 && f < win_ch_q.size(); f++) begin
      n_cmp++; if (win_ch_q[f] !== CH_W'(exp_wc[f])) begin n_fail++; $display("FAIL b2b_win_ch[%0d]: got %0d want %0d", f, win_ch_q[f], exp_wc[f]); end
      n_cmp++; if (win_val_q[f] !== W'(exp_wv[f])) begin n_fail++; $display("FAIL b2b_win_value[%0d]: got %0d want %0d", f, win_val_q[f], exp_wv[f]); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_passthrough();
    test_gate_modes();
    test_backpressure();
    test_early_last_and_race();
    test_mid_frame_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
